// File: rtl/soc_ar_arbiter_if.sv
// AR-channel bundle around soc_ar_arbiter: upstream per-master AR, downstream AR and the R monitor.
// The arbiter takes the slave view; drivers and models take the master view.
interface soc_ar_arbiter_if #(
   parameter int unsigned NrMasters = 2,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned AddrWidth = 64
);
   localparam int unsigned MIdWidth = IdWidth + $clog2(NrMasters);

   logic [NrMasters-1:0]                s_ar_valid_i;
   logic [NrMasters-1:0]                s_ar_ready_o;
   logic [NrMasters-1:0][AddrWidth-1:0] s_ar_addr_i;
   logic [NrMasters-1:0][IdWidth-1:0]   s_ar_id_i;
   logic [NrMasters-1:0][7:0]           s_ar_len_i;

   logic                 m_ar_valid_o;
   logic                 m_ar_ready_i;
   logic [AddrWidth-1:0] m_ar_addr_o;
   logic [MIdWidth-1:0]  m_ar_id_o;
   logic [7:0]           m_ar_len_o;
   logic [3:0]           m_ar_slave_o;
   logic                 m_ar_decerr_o;

   logic                 r_valid_i;
   logic                 r_ready_i;
   logic                 r_last_i;
   logic [MIdWidth-1:0]  r_id_i;

   modport slave (
      input  s_ar_valid_i, s_ar_addr_i, s_ar_id_i, s_ar_len_i, m_ar_ready_i,
             r_valid_i, r_ready_i, r_last_i, r_id_i,
      output s_ar_ready_o, m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o,
             m_ar_slave_o, m_ar_decerr_o
   );

   modport master (
      output s_ar_valid_i, s_ar_addr_i, s_ar_id_i, s_ar_len_i, m_ar_ready_i,
             r_valid_i, r_ready_i, r_last_i, r_id_i,
      input  s_ar_ready_o, m_ar_valid_o, m_ar_addr_o, m_ar_id_o, m_ar_len_o,
             m_ar_slave_o, m_ar_decerr_o
   );
endinterface

// File: rtl/soc_ar_arbiter.sv
// Round-robin AR arbiter with SoC address decode and per-master outstanding-read limiting.
// One AR is forwarded every two cycles (IDLE grant, HOLD until downstream ready).
module soc_ar_arbiter_cnt #(
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   input  logic       dec_i,
   output logic [7:0] cnt_o,
   output logic       avail_o
);
   logic [7:0] cnt_q, cnt_d;
   logic       dec_eff;

   // A completion with nothing in flight is dropped before netting against an issue.
   assign dec_eff = dec_i && (cnt_q != 8'd0);

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_eff)      cnt_d = cnt_q + 8'd1;
      else if (dec_eff && !inc_i) cnt_d = cnt_q - 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= 8'd0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o   = cnt_q;
   assign avail_o = cnt_q < 8'(MaxOutstanding);
endmodule

module soc_ar_arbiter #(
   parameter int unsigned NrMasters      = 2,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   soc_ar_arbiter_if.slave           bus,
   output logic [NrMasters-1:0][7:0] outstanding_o
);
   localparam int unsigned MW       = $clog2(NrMasters);
   localparam int unsigned MIdWidth = IdWidth + MW;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   function automatic logic in_rng(logic [64:0] a, logic [64:0] base, logic [64:0] len);
      return (a >= base) && (a < base + len);
   endfunction

   // Returns {decerr, slave}; regions are disjoint so check order does not matter.
   function automatic logic [4:0] decode(logic [AddrWidth-1:0] addr);
      logic [64:0] a;
      a = 65'(addr);
      if      (in_rng(a, 65'h8000_0000, 65'h4000_0000)) return 5'd0;
      else if (in_rng(a, 65'h4000_0000, 65'h1000))      return 5'd1;
      else if (in_rng(a, 65'h3000_0000, 65'h1_0000))    return 5'd2;
      else if (in_rng(a, 65'h2000_0000, 65'h80_0000))   return 5'd3;
      else if (in_rng(a, 65'h1000_0000, 65'h1000))      return 5'd4;
      else if (in_rng(a, 65'h0C00_0000, 65'h3FF_FFFF))  return 5'd5;
      else if (in_rng(a, 65'h0200_0000, 65'hC_0000))    return 5'd6;
      else if (in_rng(a, 65'h0001_0000, 65'h1_0000))    return 5'd7;
      else if (in_rng(a, 65'h0,         65'h1000))      return 5'd8;
      else                                              return 5'b1_0000;
   endfunction

   logic [0:0]           state_q, state_d;
   logic [MW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [AddrWidth-1:0] addr_q;
   logic [MIdWidth-1:0]  id_q;
   logic [7:0]           len_q;
   logic [3:0]           slave_q;
   logic                 decerr_q;

   logic [NrMasters-1:0] avail, elig, ready;
   logic [MW-1:0]        gnt_idx, cand;
   logic                 gnt_found, load;
   logic [4:0]           dec_res;
   logic                 r_fire;

   assign elig   = bus.s_ar_valid_i & avail;
   assign r_fire = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < int'(NrMasters); i++) begin
         cand = rr_ptr_q + MW'(i);
         if (!gnt_found && elig[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      ready    = '0;
      load     = 1'b0;
      if (state_q == IDLE) begin
         if (gnt_found && !rst_i) begin
            ready[gnt_idx] = 1'b1;
            load           = 1'b1;
            rr_ptr_d       = gnt_idx + 1'b1;
            state_d        = HOLD;
         end
      end else if (bus.m_ar_ready_i) begin
         state_d = IDLE;
      end
   end

   assign dec_res = decode(bus.s_ar_addr_i[gnt_idx]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         id_q     <= '0;
         len_q    <= '0;
         slave_q  <= '0;
         decerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (load) begin
            addr_q   <= bus.s_ar_addr_i[gnt_idx];
            id_q     <= {gnt_idx, bus.s_ar_id_i[gnt_idx]};
            len_q    <= bus.s_ar_len_i[gnt_idx];
            slave_q  <= dec_res[3:0];
            decerr_q <= dec_res[4];
         end
      end
   end

   for (genvar j = 0; j < NrMasters; j++) begin : g_cnt
      soc_ar_arbiter_cnt #(.MaxOutstanding(MaxOutstanding)) u_cnt (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .inc_i   (load && (gnt_idx == MW'(j))),
         .dec_i   (r_fire && ((bus.r_id_i >> IdWidth) == MIdWidth'(j))),
         .cnt_o   (outstanding_o[j]),
         .avail_o (avail[j])
      );
   end

   assign bus.s_ar_ready_o  = ready;
   assign bus.m_ar_valid_o  = (state_q == HOLD);
   assign bus.m_ar_addr_o   = addr_q;
   assign bus.m_ar_id_o     = id_q;
   assign bus.m_ar_len_o    = len_q;
   assign bus.m_ar_slave_o  = slave_q;
   assign bus.m_ar_decerr_o = decerr_q;
endmodule
